// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types and helpers for the BCD countdown timer
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Clamp a raw nibble to a legal BCD digit (10..15 become 9).
    function automatic bcd_digit_t sat_digit(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// rtl/bcd_digit_down.sv - one BCD digit of a ripple-borrow decrementer
//   digit      : current BCD digit (assumed 0..9)
//   borrow_in  : 1 = subtract one from this digit
//   next_digit : decremented (or passed-through) digit
//   borrow_out : 1 when this digit wrapped 0 -> 9 and needs the next digit to pay
module bcd_digit_down
    import countdown_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                next_digit = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer_bcd.sv
// rtl/countdown_timer_bcd.sv - loadable, pausable BCD down-counter with expiry flag
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high
//   load       : pulse, load load_value (digits clamped to 9) and go IDLE
//   load_value : BCD start value, digit 0 in [3:0]
//   start      : pulse, IDLE -> RUN (or EXPIRED if count is 0), PAUSED -> RUN
//   pause      : pulse, RUN -> PAUSED
//   count_bcd  : registered current count
//   running    : state is RUN
//   expired    : state is EXPIRED
//   done       : one-cycle registered pulse on reaching zero
module countdown_timer_bcd
    import countdown_pkg::*;
#(
    parameter int N_DIGITS = 2,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_value,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*N_DIGITS-1:0] count_bcd,
    output logic                  running,
    output logic                  expired,
    output logic                  done
);

    localparam int CW = 4 * N_DIGITS;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    timer_state_t  state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [CW-1:0] count_n;
    logic          done_n;

    logic [CW-1:0]     load_sat;
    logic [CW-1:0]     count_dec;
    logic [N_DIGITS:0] borrow;

    // Ripple-borrow decrement of the whole count, one digit cell per nibble.
    assign borrow[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < N_DIGITS; g++) begin : g_digit
            bcd_digit_down u_digit (
                .digit      (count_bcd[g*4 +: 4]),
                .borrow_in  (borrow[g]),
                .next_digit (count_dec[g*4 +: 4]),
                .borrow_out (borrow[g+1])
            );
        end
    endgenerate

    always_comb begin
        load_sat = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            load_sat[i*4 +: 4] = sat_digit(load_value[i*4 +: 4]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            count_bcd <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            count_bcd <= count_n;
            done      <= done_n;
        end
    end

    // Priority: load > pause > start > tick.
    always_comb begin
        state_n = state;
        presc_n = presc;
        count_n = count_bcd;
        done_n  = 1'b0;

        if (load) begin
            state_n = IDLE;
            presc_n = '0;
            count_n = load_sat;
        end else if (pause) begin
            // A simultaneous start is swallowed here as well.
            if (state == RUN) begin
                state_n = PAUSED;
            end
        end else if (start && (state == IDLE || state == PAUSED)) begin
            if (state == IDLE) begin
                presc_n = '0;
                if (count_bcd == '0) begin
                    state_n = EXPIRED;
                    done_n  = 1'b1;
                end else begin
                    state_n = RUN;
                end
            end else begin
                // Resume keeps the partially elapsed period.
                state_n = RUN;
            end
        end else if (state == RUN) begin
            if (presc == PRESC_LAST) begin
                presc_n = '0;
                // A borrow out of the top digit would mean wrapping to 99..9;
                // pin at zero instead so expiry can never wrap.
                count_n = borrow[N_DIGITS] ? '0 : count_dec;
                if (borrow[N_DIGITS] || count_dec == '0) begin
                    state_n = EXPIRED;
                    done_n  = 1'b1;
                end
            end else begin
                presc_n = presc + 1'b1;
            end
        end
    end

    assign running = (state == RUN);
    assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// tb/tb_countdown_timer_bcd.sv - directed self-checking bench for countdown_timer_bcd
module tb_countdown_timer_bcd;

    logic       clock;
    logic       reset;
    logic       load;
    logic [7:0] load_value;
    logic       start;
    logic       pause;
    logic [7:0] count_bcd;
    logic       running;
    logic       expired;
    logic       done;

    int checks = 0;
    int errors = 0;

    countdown_timer_bcd #(
        .N_DIGITS (2),
        .TICK_DIV (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .count_bcd  (count_bcd),
        .running    (running),
        .expired    (expired),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_value = v;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        step(1);
        pause = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        load = 1'b0;
        load_value = 8'h00;
        start = 1'b0;
        pause = 1'b0;
        step(2);
        reset = 1'b0;
        check("rst_count", count_bcd, 8'h00);
        check("rst_running", running, 1'b0);
        check("rst_expired", expired, 1'b0);
        check("rst_done", done, 1'b0);

        // Reset in the middle of a run
        do_load(8'h07);
        do_start();
        check("r_running", running, 1'b1);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("r_count", count_bcd, 8'h00);
        check("r_running0", running, 1'b0);
        check("r_expired", expired, 1'b0);
        check("r_done", done, 1'b0);

        // 12 -> 11 -> 10 -> 09 with tick latency of 4
        do_load(8'h12);
        check("t12_load", count_bcd, 8'h12);
        do_start();
        check("t12_running", running, 1'b1);
        step(3);
        check("t12_before", count_bcd, 8'h12);
        step(1);
        check("t12_11", count_bcd, 8'h11);
        step(4);
        check("t12_10", count_bcd, 8'h10);
        step(4);
        check("t12_09", count_bcd, 8'h09);

        // Run to zero: done pulse, expired latch, start ignored
        do_load(8'h02);
        do_start();
        step(4);
        check("t02_01", count_bcd, 8'h01);
        step(3);
        check("t02_pre_done", done, 1'b0);
        step(1);
        check("t02_00", count_bcd, 8'h00);
        check("t02_done", done, 1'b1);
        check("t02_expired", expired, 1'b1);
        check("t02_running", running, 1'b0);
        step(1);
        check("t02_done_low", done, 1'b0);
        check("t02_exp_hold", expired, 1'b1);
        do_start();
        check("t02_st_exp", expired, 1'b1);
        check("t02_st_run", running, 1'b0);
        check("t02_st_done", done, 1'b0);
        step(5);
        check("t02_nowrap", count_bcd, 8'h00);

        // Pause keeps prescaler; resume decrements after remaining 2 cycles
        do_load(8'h05);
        do_start();
        step(2);
        do_pause();
        check("p_running", running, 1'b0);
        check("p_count", count_bcd, 8'h05);
        step(10);
        check("p_hold", count_bcd, 8'h05);
        do_start();
        check("p_resume", running, 1'b1);
        step(1);
        check("p_resume1", count_bcd, 8'h05);
        step(1);
        check("p_resume2", count_bcd, 8'h04);

        // Invalid digit clamp, start+pause together
        do_load(8'h3A);
        check("clamp", count_bcd, 8'h39);
        start = 1'b1;
        pause = 1'b1;
        step(1);
        start = 1'b0;
        pause = 1'b0;
        check("sp_running", running, 1'b0);
        check("sp_expired", expired, 1'b0);
        step(5);
        check("sp_count", count_bcd, 8'h39);

        // Start at zero goes straight to expired
        do_load(8'h00);
        do_start();
        check("z_expired", expired, 1'b1);
        check("z_done", done, 1'b1);
        check("z_count", count_bcd, 8'h00);
        step(1);
        check("z_done_low", done, 1'b0);

        // Load mid-run restarts the prescaler
        do_load(8'h10);
        do_start();
        step(2);
        do_load(8'h50);
        check("ml_running", running, 1'b0);
        check("ml_count", count_bcd, 8'h50);
        do_start();
        step(3);
        check("ml_before", count_bcd, 8'h50);
        step(1);
        check("ml_49", count_bcd, 8'h49);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
